// File: rtl/key_round_gen_if.sv
// Bundle of the handshake, key and sub_bytes_four signals for key_round_gen.
// The master side is the requester/consumer; the slave side is the key generator.
interface key_round_gen_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key_in;
    logic [3:0]   round_in;
    logic [31:0]  sub_word_out;
    logic [3:0]   sub_round_out;
    logic [31:0]  sub_word_in;
    logic [3:0]   sub_round_in;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         out_valid;
    logic         out_ready;
    logic         err;

    modport master (
        output in_valid, key_in, round_in, sub_word_in, sub_round_in, out_ready,
        input  in_ready, sub_word_out, sub_round_out, key_out, round_out, out_valid, err
    );

    modport slave (
        input  in_valid, key_in, round_in, sub_word_in, sub_round_in, out_ready,
        output in_ready, sub_word_out, sub_round_out, key_out, round_out, out_valid, err
    );
endinterface

// File: rtl/key_round_gen.sv
// AES-128 key-expansion round: derives round key N from round key N-1, one word per
// cycle, using an external combinational SubWord unit (sub_bytes_four).
module key_round_gen (
    input logic            clk,
    input logic            rst_n,
    key_round_gen_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StSub, StW0, StW1, StW2, StW3, StDone} state_e;

    state_e       state_q, state_d;
    logic [127:0] kreg_q, kreg_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [31:0]  temp_q, temp_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_out_q, round_out_d;
    logic         out_valid_q, out_valid_d;
    logic         err_q, err_d;
    logic         round_legal;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign round_legal = (bus.round_in >= 4'd1) && (bus.round_in <= 4'd10);

    always_comb begin
        state_d     = state_q;
        kreg_d      = kreg_q;
        rnd_d       = rnd_q;
        temp_d      = temp_q;
        key_d       = key_q;
        round_out_d = round_out_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (round_legal) begin
                        kreg_d  = bus.key_in;
                        rnd_d   = bus.round_in;
                        state_d = StSub;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StSub: begin
                if (bus.sub_round_in != rnd_q) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    temp_d  = bus.sub_word_in;
                    state_d = StW0;
                end
            end
            StW0: begin
                key_d[127:96] = kreg_q[127:96] ^ temp_q ^ {rcon(rnd_q), 24'h0};
                state_d       = StW1;
            end
            StW1: begin
                key_d[95:64] = key_q[127:96] ^ kreg_q[95:64];
                state_d      = StW2;
            end
            StW2: begin
                key_d[63:32] = key_q[95:64] ^ kreg_q[63:32];
                state_d      = StW3;
            end
            StW3: begin
                key_d[31:0] = key_q[63:32] ^ kreg_q[31:0];
                round_out_d = rnd_q;
                state_d     = StDone;
            end
            StDone: begin
                // out_valid is registered, so it rises on the first edge spent in DONE
                out_valid_d = 1'b1;
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            kreg_q      <= '0;
            rnd_q       <= '0;
            temp_q      <= '0;
            key_q       <= '0;
            round_out_q <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            kreg_q      <= kreg_d;
            rnd_q       <= rnd_d;
            temp_q      <= temp_d;
            key_q       <= key_d;
            round_out_q <= round_out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready      = (state_q == StIdle);
    assign bus.sub_word_out  = {kreg_q[23:0], kreg_q[31:24]};
    assign bus.sub_round_out = rnd_q;
    assign bus.key_out       = key_q;
    assign bus.round_out     = round_out_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_key_round_gen.sv
// Directed bench for key_round_gen: models sub_bytes_four with an AES S-box and
// checks FIPS-197 vectors, latency, backpressure, illegal rounds and reset.
module tb_key_round_gen;

    logic clk;
    logic rst_n;
    logic mismatch;
    int   n_checks;
    int   n_errs;

    key_round_gen_if bus ();

    key_round_gen u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [2047:0] sbox_bits = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Combinational sub_bytes_four model; mismatch corrupts the returned round
    always_comb begin
        bus.sub_word_in = {sbox_bits[2047 - 8 * int'(bus.sub_word_out[31:24]) -: 8],
                           sbox_bits[2047 - 8 * int'(bus.sub_word_out[23:16]) -: 8],
                           sbox_bits[2047 - 8 * int'(bus.sub_word_out[15:8]) -: 8],
                           sbox_bits[2047 - 8 * int'(bus.sub_word_out[7:0]) -: 8]};
        bus.sub_round_in = bus.sub_round_out ^ {3'b000, mismatch};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, wait for out_valid, hold for `hold` cycles, handshake
    task automatic run_op(input logic [127:0] k, input logic [3:0] r, input int hold,
                          output logic [127:0] ko, output logic [3:0] ro, output int lat,
                          output logic [31:0] sw, output logic err_seen, output logic stable);
        bus.in_valid = 1'b1;
        bus.key_in   = k;
        bus.round_in = r;
        tick();
        bus.in_valid = 1'b0;
        sw       = bus.sub_word_out;
        lat      = 0;
        err_seen = bus.err;
        while (!bus.out_valid && lat < 30) begin
            tick();
            lat++;
            err_seen |= bus.err;
        end
        ko     = bus.key_out;
        ro     = bus.round_out;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (bus.key_out !== ko || bus.round_out !== ro || bus.out_valid !== 1'b1)
                stable = 1'b0;
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    logic [127:0] ko;
    logic [3:0]   ro;
    int           lat;
    logic [31:0]  sw;
    logic         es;
    logic         st;
    logic         ov_seen;
    logic [127:0] chain_key;

    initial begin
        n_checks      = 0;
        n_errs        = 0;
        mismatch      = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.key_in    = '0;
        bus.round_in  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", bus.in_ready, 1'b1);
        check_eq("rst_key_out", bus.key_out, 128'h0);
        check_eq("rst_round_out", bus.round_out, 4'h0);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_err", bus.err, 1'b0);
        rst_n = 1'b1;
        tick();

        // FIPS-197 round 1
        check_eq("r1_in_ready_pre", bus.in_ready, 1'b1);
        run_op(128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd1, 0, ko, ro, lat, sw, es, st);
        check_eq("r1_sub_word", sw, 32'hcf4f3c09);
        check_eq("r1_latency", lat, 6);
        check_eq("r1_key", ko, 128'ha0fafe1788542cb123a339392a6c7605);
        check_eq("r1_round", ro, 4'd1);
        check_eq("r1_no_err", es, 1'b0);
        check_eq("r1_idle_after", bus.in_ready, 1'b1);
        check_eq("r1_valid_drop", bus.out_valid, 1'b0);

        // Round 10 (rcon 36) with 20 cycles of backpressure
        run_op(128'hac7766f319fadc2128d12941575c006e, 4'd10, 20, ko, ro, lat, sw, es, st);
        check_eq("r10_key", ko, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_eq("r10_round", ro, 4'd10);
        check_eq("r10_stable", st, 1'b1);
        check_eq("r10_idle_after", bus.in_ready, 1'b1);

        // Illegal rounds 0 and 11: consumed, err pulse, key_out untouched
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.key_in   = 128'h0123456789abcdef0123456789abcdef;
            bus.round_in = (i == 0) ? 4'd0 : 4'd11;
            check_eq("ill_in_ready", bus.in_ready, 1'b1);
            tick();
            bus.in_valid = 1'b0;
            check_eq("ill_err_pulse", bus.err, 1'b1);
            check_eq("ill_stay_idle", bus.in_ready, 1'b1);
            check_eq("ill_no_valid", bus.out_valid, 1'b0);
            check_eq("ill_key_kept", bus.key_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            tick();
            check_eq("ill_err_low", bus.err, 1'b0);
        end

        // Round mismatch from sub_bytes_four
        mismatch     = 1'b1;
        bus.in_valid = 1'b1;
        bus.key_in   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        bus.round_in = 4'd3;
        tick();
        bus.in_valid = 1'b0;
        check_eq("mm_err_before", bus.err, 1'b0);
        tick();
        mismatch = 1'b0;
        check_eq("mm_err_pulse", bus.err, 1'b1);
        check_eq("mm_back_idle", bus.in_ready, 1'b1);
        ov_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            ov_seen |= bus.out_valid;
        end
        check_eq("mm_no_valid", ov_seen, 1'b0);

        // Reset dropped during W2
        bus.in_valid = 1'b1;
        bus.key_in   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        bus.round_in = 4'd1;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check_eq("w2_busy", bus.in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_key", bus.key_out, 128'h0);
        check_eq("mid_rst_round", bus.round_out, 4'h0);
        check_eq("mid_rst_valid", bus.out_valid, 1'b0);
        check_eq("mid_rst_err", bus.err, 1'b0);
        check_eq("mid_rst_subw", bus.sub_word_out, 32'h0);
        check_eq("mid_rst_ready", bus.in_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd1, 0, ko, ro, lat, sw, es, st);
        check_eq("post_rst_key", ko, 128'ha0fafe1788542cb123a339392a6c7605);
        check_eq("post_rst_latency", lat, 6);

        // Full chain through rounds 1..10
        chain_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        for (int r = 1; r <= 10; r++) begin
            run_op(chain_key, 4'(r), 0, ko, ro, lat, sw, es, st);
            chain_key = ko;
            if (r == 1) check_eq("chain_r1", ko, 128'ha0fafe1788542cb123a339392a6c7605);
        end
        check_eq("chain_r10", chain_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_eq("chain_r10_round", ro, 4'd10);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
